// File: rtl/rdm_row_sender.sv
// Row sender: drains ROW_LEN-sample rows from the upstream FIFO as contiguous bursts separated by idle gaps.
// Optional feature macro RDM_TX_FRAME_EN: frame_start begins a frame of NUM_ROWS rows, and frame_done marks the end of the frame.
module rdm_row_sender #(
    parameter int ROW_LEN  = 64,
    parameter int ROW_GAP  = 48,
    parameter int NUM_ROWS = 512
) (
    input  logic        clk_100mhz,
    input  logic        reset_n,
    input  logic [7:0]  fifo_dout,
    input  logic        fifo_empty,
    input  logic [11:0] fifo_count,
    output logic        fifo_rd_en,
    output logic        rdm_data_tvalid,
    output logic [7:0]  rdm_amp_data,
    output logic        rdm_fifo_empty,
    output logic        row_done,
    output logic [11:0] row_idx,
    input  logic        frame_start,
    output logic        frame_done,
    output logic [1:0]  dbg_state
);
    // Neither interface has back-pressure. Each cycle that fifo_rd_en is high, the FIFO returns
    // one word on fifo_dout in the following cycle. rdm_data_tvalid qualifies that word and
    // has no ready signal, so a row, once started, is never stalled.
    localparam int GW = $clog2(ROW_GAP + 1);

`ifdef RDM_TX_FRAME_EN
    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_WAIT_FRAME} state_t;
    localparam state_t RESET_STATE = S_WAIT_FRAME;
`else
    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;
    localparam state_t RESET_STATE = S_IDLE;
`endif

    state_t          r_state;
    state_t          w_next_state;
    state_t          w_gap_exit;
    logic [11:0]     r_cnt;
    logic [GW-1:0]   r_gap_cnt;
    logic            r_tvalid;
    logic            r_empty_d;
    logic            r_row_done;
    logic [11:0]     r_row_idx;
    logic            w_start_row;
    logic            w_empty_fall;
    logic            w_rd_en;

    assign w_rd_en      = (r_state == S_SEND);
    assign w_empty_fall = r_empty_d & ~fifo_empty;

    always_comb begin
        w_next_state = r_state;
        w_start_row  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (fifo_count >= 12'(ROW_LEN) && !fifo_empty) begin
                    w_next_state = S_SEND;
                    w_start_row  = 1'b1;
                end
            end
            S_SEND: begin
                if (r_cnt == 12'(ROW_LEN - 1)) w_next_state = S_GAP;
            end
            S_GAP: begin
                // The last sample is still on the output during the first GAP cycle.
                // Staying for ROW_GAP+1 cycles therefore leaves ROW_GAP silent cycles.
                if (r_gap_cnt == GW'(ROW_GAP)) w_next_state = w_gap_exit;
            end
`ifdef RDM_TX_FRAME_EN
            S_WAIT_FRAME: begin
                if (frame_start) w_next_state = S_IDLE;
            end
`endif
            default: w_next_state = RESET_STATE;
        endcase
    end

    always_ff @(posedge clk_100mhz) begin
        if (!reset_n) begin
            r_state    <= RESET_STATE;
            r_cnt      <= 12'd0;
            r_gap_cnt  <= '0;
            r_tvalid   <= 1'b0;
            r_empty_d  <= 1'b1;
            r_row_done <= 1'b0;
            r_row_idx  <= 12'd0;
        end else begin
            r_state    <= w_next_state;
            r_tvalid   <= w_rd_en;
            r_empty_d  <= fifo_empty;
            r_row_done <= r_tvalid & ~w_rd_en;
            r_cnt      <= (r_state == S_SEND) ? r_cnt + 12'd1 : 12'd0;
            r_gap_cnt  <= (r_state == S_GAP) ? r_gap_cnt + GW'(1) : '0;
            // A new row wins over the FIFO-refill clear, so the first row after the clear is row 1.
            if (w_start_row)
                r_row_idx <= w_empty_fall ? 12'd1 : r_row_idx + 12'd1;
            else if (w_empty_fall)
                r_row_idx <= 12'd0;
        end
    end

`ifdef RDM_TX_FRAME_EN
    localparam int FW = $clog2(NUM_ROWS + 1);

    logic [FW-1:0] r_frame_rows;
    logic          r_frame_done;

    assign w_gap_exit = (r_frame_rows == FW'(NUM_ROWS)) ? S_WAIT_FRAME : S_IDLE;

    always_ff @(posedge clk_100mhz) begin
        if (!reset_n) begin
            r_frame_rows <= '0;
            r_frame_done <= 1'b0;
        end else begin
            if (r_state == S_WAIT_FRAME && frame_start)
                r_frame_rows <= '0;
            else if (w_start_row)
                r_frame_rows <= r_frame_rows + FW'(1);
            r_frame_done <= r_tvalid & ~w_rd_en & (r_frame_rows == FW'(NUM_ROWS));
        end
    end

    assign frame_done = r_frame_done;
`else
    localparam int UNUSED_NUM_ROWS = NUM_ROWS;
    logic w_unused_frame_start;

    assign w_unused_frame_start = frame_start;
    assign w_gap_exit           = S_IDLE;
    assign frame_done           = 1'b0;
`endif

    assign fifo_rd_en      = w_rd_en;
    assign rdm_data_tvalid = r_tvalid;
    assign rdm_amp_data    = r_tvalid ? fifo_dout : 8'd0;
    assign rdm_fifo_empty  = r_empty_d;
    assign row_done        = r_row_done;
    assign row_idx         = r_row_idx;
    assign dbg_state       = r_state;

endmodule
